// File: rtl/sevseg_scan_ndigit.sv
// Time-multiplexed hex driver for NUM_DIGITS common-anode seven-segment digits.
// Captures inputs once per frame and adds dead time, PWM dimming, blink and leading-zero blanking.
module sevseg_scan_ndigit #(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 65536,
  parameter int DEAD_CYCLES  = 4,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lz_suppress,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] DEAD_T     = TW'(DEAD_CYCLES);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h7E;  4'h1: r = 7'h30;  4'h2: r = 7'h6D;  4'h3: r = 7'h79;
      4'h4: r = 7'h33;  4'h5: r = 7'h5B;  4'h6: r = 7'h5F;  4'h7: r = 7'h70;
      4'h8: r = 7'h7F;  4'h9: r = 7'h7B;  4'hA: r = 7'h77;  4'hB: r = 7'h1F;
      4'hC: r = 7'h4E;  4'hD: r = 7'h3D;  4'hE: r = 7'h4F;  default: r = 7'h47;
    endcase
    return r;
  endfunction

  logic [TW-1:0]           tick_q, tick_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [PWM_BITS-1:0]     pwm_q, pwm_d;
  logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic                    load_pending_q, load_pending_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic                    sh_lz_q, sh_lz_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q, frame_start_d;

  logic                    tick_wrap, frame_wrap, load;
  logic                    zero_run, lit;
  logic [NUM_DIGITS-1:0]   lz_dark, digit_dark;
  logic [3:0]              cur_val;

  always_comb begin
    tick_wrap      = (tick_q == TICK_LAST);
    frame_wrap     = tick_wrap && (digit_q == DIGIT_LAST);
    tick_d         = tick_wrap ? '0 : tick_q + TW'(1);
    digit_d        = digit_q;
    if (tick_wrap) digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
    pwm_d          = pwm_q + PWM_BITS'(1);
    frame_cnt_d    = frame_cnt_q;
    blink_phase_d  = blink_phase_q;
    if (frame_wrap) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + FW'(1);
      end
    end
    load_pending_d = 1'b0;
    // Inputs are sampled only at frame boundaries so a frame never mixes old and new values.
    load           = load_pending_q || frame_wrap;
    sh_digits_d    = load ? digits      : sh_digits_q;
    sh_dp_d        = load ? dp_in       : sh_dp_q;
    sh_blank_d     = load ? blank_in    : sh_blank_q;
    sh_blink_d     = load ? blink_in    : sh_blink_q;
    sh_lz_d        = load ? lz_suppress : sh_lz_q;
  end

  always_comb begin
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (sh_digits_q[4*i +: 4] == 4'h0);
      lz_dark[i] = sh_lz_q && zero_run;
    end
    digit_dark    = sh_blank_q | (sh_blink_q & {NUM_DIGITS{blink_phase_q}}) | lz_dark;
    cur_val       = sh_digits_q[{digit_q, 2'b00} +: 4];
    lit           = enable && (tick_q >= DEAD_T) &&
                    ((&brightness) || (pwm_q < brightness)) && !digit_dark[digit_q];
    an_d          = '1;
    seg_d         = 7'h7F;
    dp_d          = 1'b1;
    if (lit) begin
      an_d[digit_q] = 1'b0;
      seg_d         = ~hex_decode(cur_val);
      dp_d          = ~sh_dp_q[digit_q];
    end
    frame_start_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q         <= '0;
      digit_q        <= '0;
      pwm_q          <= '0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      load_pending_q <= 1'b1;
      sh_digits_q    <= '0;
      sh_dp_q        <= '0;
      sh_blank_q     <= '1;
      sh_blink_q     <= '0;
      sh_lz_q        <= 1'b0;
      an_q           <= '1;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
      frame_start_q  <= 1'b0;
    end else begin
      tick_q         <= tick_d;
      digit_q        <= digit_d;
      pwm_q          <= pwm_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      load_pending_q <= load_pending_d;
      sh_digits_q    <= sh_digits_d;
      sh_dp_q        <= sh_dp_d;
      sh_blank_q     <= sh_blank_d;
      sh_blink_q     <= sh_blink_d;
      sh_lz_q        <= sh_lz_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevseg_scan_ndigit.sv
// Directed bench for sevseg_scan_ndigit with 4 digits, 8-clock slots and 2 dead cycles.
module tb_sevseg_scan_ndigit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_in, blank_in, blink_in;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int frames_seen;

  logic [6:0] seg_1234 [4] = '{7'h4C, 7'h06, 7'h12, 7'h4F};
  logic [6:0] seg_5678 [4] = '{7'h00, 7'h0F, 7'h20, 7'h24};

  always #5 clk = ~clk;

  sevseg_scan_ndigit #(
    .NUM_DIGITS(4), .TICK_DIV(8), .DEAD_CYCLES(2), .PWM_BITS(2), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .lz_suppress(lz_suppress),
    .brightness(brightness), .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  // Frame boundaries seen since the last reset; sets the expected blink phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) frames_seen <= 0;
    else if (frame_start) frames_seen <= frames_seen + 1;
  end

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; digits = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
    blink_in = 4'h0; lz_suppress = 1'b0; brightness = 2'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset an=%h seg=%h dp=%b fs=%b expected an=f seg=7f dp=1 fs=0", an, seg, dp, frame_start);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    bit ok;
    logic [3:0] ea; logic [6:0] es; logic ef;
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL scan_sync no frame_start seen, expected one within 100 clocks"); end
    for (int k = 1; k <= 32; k++) begin
      int s, t;
      @(posedge clk); @(negedge clk);
      s = (k - 1) / 8; t = (k - 1) % 8;
      ea = (t >= 2) ? ~(4'b0001 << s) : 4'hF;
      es = (t >= 2) ? seg_1234[s] : 7'h7F;
      ef = (k == 32);
      checks++;
      if ({an, seg, dp, frame_start} !== {ea, es, 1'b1, ef}) begin
        errors++;
        $display("[TB] FAIL scan k=%0d an=%h seg=%h dp=%b fs=%b expected an=%h seg=%h dp=1 fs=%b", k, an, seg, dp, frame_start, ea, es, ef);
      end
    end
  endtask

  task automatic test_frame_capture();
    logic [3:0] ea; logic [6:0] es; logic ef;
    for (int k = 1; k <= 64; k++) begin
      int s, t;
      @(posedge clk); @(negedge clk);
      s = ((k - 1) % 32) / 8; t = (k - 1) % 8;
      ea = (t >= 2) ? ~(4'b0001 << s) : 4'hF;
      es = (t < 2) ? 7'h7F : (k <= 32) ? seg_1234[s] : seg_5678[s];
      ef = (k % 32 == 0);
      checks++;
      if ({an, seg, dp, frame_start} !== {ea, es, 1'b1, ef}) begin
        errors++;
        $display("[TB] FAIL capture k=%0d an=%h seg=%h dp=%b fs=%b expected an=%h seg=%h dp=1 fs=%b", k, an, seg, dp, frame_start, ea, es, ef);
      end
      if (k == 9) digits = 16'h5678;
    end
  endtask

  task automatic test_lz();
    bit ok;
    logic [3:0] ea; logic [6:0] es; logic lit;
    lz_suppress = 1'b1;
    for (int p = 0; p < 2; p++) begin
      digits = (p == 0) ? 16'h0070 : 16'h0000;
      wait_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL lz_sync p=%0d no frame_start seen", p); end
      for (int k = 1; k <= 32; k++) begin
        int s, t;
        @(posedge clk); @(negedge clk);
        s = (k - 1) / 8; t = (k - 1) % 8;
        lit = (t >= 2) && (s == 0 || (p == 0 && s == 1));
        ea = lit ? ~(4'b0001 << s) : 4'hF;
        es = !lit ? 7'h7F : (s == 0) ? 7'h01 : 7'h0F;
        checks++;
        if ({an, seg, dp} !== {ea, es, 1'b1}) begin
          errors++;
          $display("[TB] FAIL lz p=%0d k=%0d an=%h seg=%h dp=%b expected an=%h seg=%h dp=1", p, k, an, seg, dp, ea, es);
        end
      end
    end
  endtask

  task automatic test_brightness();
    bit ok;
    logic [3:0] ea; logic [6:0] es; logic lit;
    digits = 16'h1234; lz_suppress = 1'b0; brightness = 2'd3;
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL bright_sync no frame_start seen"); end
    brightness = 2'd1;
    for (int k = 1; k <= 64; k++) begin
      int s, t;
      @(posedge clk); @(negedge clk);
      s = ((k - 1) % 32) / 8; t = (k - 1) % 8;
      lit = (k <= 32) && (t == 4);
      ea = lit ? ~(4'b0001 << s) : 4'hF;
      es = lit ? seg_1234[s] : 7'h7F;
      checks++;
      if ({an, seg, dp} !== {ea, es, 1'b1}) begin
        errors++;
        $display("[TB] FAIL bright k=%0d an=%h seg=%h dp=%b expected an=%h seg=%h dp=1", k, an, seg, dp, ea, es);
      end
      if (k == 32) brightness = 2'd0;
    end
  endtask

  task automatic test_blink_dp();
    bit ok;
    int phase;
    logic [3:0] ea; logic [6:0] es; logic ed, lit;
    brightness = 2'd3; blink_in = 4'b0001; dp_in = 4'b0010;
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL blink_sync no frame_start seen"); end
    phase = 0;
    for (int k = 1; k <= 128; k++) begin
      int s, t;
      @(posedge clk); @(negedge clk);
      if ((k - 1) % 32 == 0) phase = (frames_seen >> 1) & 1;
      s = ((k - 1) % 32) / 8; t = (k - 1) % 8;
      lit = (t >= 2) && !(s == 0 && phase == 1);
      ea = lit ? ~(4'b0001 << s) : 4'hF;
      es = lit ? seg_1234[s] : 7'h7F;
      ed = !(lit && s == 1);
      checks++;
      if ({an, seg, dp} !== {ea, es, ed}) begin
        errors++;
        $display("[TB] FAIL blink k=%0d phase=%0d an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b", k, phase, an, seg, dp, ea, es, ed);
      end
    end
  endtask

  task automatic test_enable_reset();
    bit ok;
    logic [3:0] ea; logic [6:0] es; logic ef, lit;
    blink_in = 4'h0; dp_in = 4'h0;
    wait_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL enable_sync no frame_start seen"); end
    for (int k = 1; k <= 84; k++) begin
      int s, t;
      @(posedge clk); @(negedge clk);
      s = ((k - 1) % 32) / 8; t = (k - 1) % 8;
      lit = (t >= 2) && (k <= 12 || k >= 41);
      ea = lit ? ~(4'b0001 << s) : 4'hF;
      es = lit ? seg_1234[s] : 7'h7F;
      ef = (k % 32 == 0);
      checks++;
      if ({an, seg, dp, frame_start} !== {ea, es, 1'b1, ef}) begin
        errors++;
        $display("[TB] FAIL enable k=%0d an=%h seg=%h dp=%b fs=%b expected an=%h seg=%h dp=1 fs=%b", k, an, seg, dp, frame_start, ea, es, ef);
      end
      if (k == 12) enable = 1'b0;
      if (k == 40) enable = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset an=%h seg=%h dp=%b fs=%b expected an=f seg=7f dp=1 fs=0", an, seg, dp, frame_start);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      int s, t;
      @(posedge clk); @(negedge clk);
      s = (n - 1) / 8; t = (n - 1) % 8;
      ea = (t >= 2) ? ~(4'b0001 << s) : 4'hF;
      es = (t >= 2) ? seg_1234[s] : 7'h7F;
      ef = (n == 32);
      checks++;
      if ({an, seg, dp, frame_start} !== {ea, es, 1'b1, ef}) begin
        errors++;
        $display("[TB] FAIL restart n=%0d an=%h seg=%h dp=%b fs=%b expected an=%h seg=%h dp=1 fs=%b", n, an, seg, dp, frame_start, ea, es, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_capture();
    test_lz();
    test_brightness();
    test_blink_dp();
    test_enable_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
